// File: rtl/uart_pkg.sv
// Shared defaults and receiver state encoding for the UART RX + FIFO slice.
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int DVSR_DEF    = 27;
    localparam int FIFO_W_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
module fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_pin,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);

    logic [B-1:0] array_reg [0:2**W-1];
    logic [W-1:0] w_ptr, r_ptr;
    logic [W-1:0] w_succ, r_succ;
    logic         do_rd, do_wr;

    // A write into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign do_rd  = rd & ~empty;
    assign do_wr  = wr & (~full | do_rd);
    assign w_succ = w_ptr + W'(1);
    assign r_succ = r_ptr + W'(1);
    assign r_data = array_reg[r_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            array_reg[w_ptr] <= w_data;
    end

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            case ({do_wr, do_rd})
                2'b01: begin
                    r_ptr <= r_succ;
                    full  <= 1'b0;
                    empty <= (r_succ == w_ptr);
                end
                2'b10: begin
                    w_ptr <= w_succ;
                    empty <= 1'b0;
                    full  <= (w_succ == r_ptr);
                end
                2'b11: begin
                    w_ptr <= w_succ;
                    r_ptr <= r_succ;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and internal baud tick, feeding a small RX FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DVSR    = DVSR_DEF,
    parameter int FIFO_W  = FIFO_W_DEF
) (
    input  logic            clk,
    input  logic            reset_pin,
    input  logic            rx,
    input  logic            rd_rx_pin,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            rx_busy
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic [CW-1:0]   tick_cnt;
    logic            s_tick;
    logic            rx_meta, rx_sync;
    logic            rd_prev, rd_pop;
    logic            rx_done;

    rx_state_t       state, state_next;
    logic [3:0]      s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;

    assign s_tick = (tick_cnt == CW'(DVSR - 1));

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin)
            tick_cnt <= '0;
        else if (s_tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rd_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rd_prev <= rd_rx_pin;
        end
    end

    // One pop per low pulse, however long the strobe is held.
    assign rd_pop = rd_prev & ~rd_rx_pin;

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            state <= IDLE;
            s_reg <= '0;
            n_reg <= '0;
            b_reg <= '0;
        end else begin
            state <= state_next;
            s_reg <= s_next;
            n_reg <= n_next;
            b_reg <= b_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        rx_done    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == 4'd7) begin
                        state_next = DATA;
                        s_next     = '0;
                        n_next     = '0;
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == 4'd15) begin
                        s_next = '0;
                        b_next = {rx_sync, b_reg[DBIT-1:1]};
                        if (n_reg == NW'(DBIT - 1))
                            state_next = STOP;
                        else
                            n_next = n_reg + NW'(1);
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == 4'(SB_TICK - 1)) begin
                        state_next = IDLE;
                        rx_done    = 1'b1;
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

    fifo #(
        .B(DBIT),
        .W(FIFO_W)
    ) fifo_unit (
        .clk      (clk),
        .reset_pin(reset_pin),
        .rd       (rd_pop),
        .wr       (rx_done),
        .w_data   (b_reg),
        .empty    (rx_empty),
        .full     (rx_full),
        .r_data   (r_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: serial frames in, FIFO head/flags checked against hand-computed values.
module tb_uart_rx_fifo;

    localparam int BIT_T = 864;

    logic       clk = 1'b0;
    logic       reset_pin = 1'b0;
    logic       rx = 1'b1;
    logic       rd_rx_pin = 1'b1;
    logic [7:0] r_data;
    logic       rx_empty, rx_full, rx_busy;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk      (clk),
        .reset_pin(reset_pin),
        .rx       (rx),
        .rd_rx_pin(rd_rx_pin),
        .r_data   (r_data),
        .rx_empty (rx_empty),
        .rx_full  (rx_full),
        .rx_busy  (rx_busy)
    );

    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one 8N1 frame; optionally checks rx_busy in the middle of data bit 3.
    task automatic send_byte(input logic [7:0] data, input bit check_busy);
        @(negedge clk);
        rx = 1'b0;
        #BIT_T;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (check_busy && i == 3) begin
                #(BIT_T / 2);
                check("busy_mid_frame", {31'b0, rx_busy}, 32'd1);
                #(BIT_T / 2);
            end else begin
                #BIT_T;
            end
        end
        rx = 1'b1;
        #BIT_T;
        #200;
    endtask

    task automatic read_pulse(input int width);
        @(negedge clk);
        rd_rx_pin = 1'b0;
        repeat (width) @(negedge clk);
        rd_rx_pin = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #4 reset_pin = 1'b1;
        @(negedge clk);
        check("reset_empty", {31'b0, rx_empty}, 32'd1);
        check("reset_full",  {31'b0, rx_full},  32'd0);
        check("reset_busy",  {31'b0, rx_busy},  32'd0);

        send_byte(8'hAB, 1'b1);
        check("ab_empty", {31'b0, rx_empty}, 32'd0);
        check("ab_data",  {24'b0, r_data},   32'hAB);
        check("ab_busy",  {31'b0, rx_busy},  32'd0);
        check("ab_full",  {31'b0, rx_full},  32'd0);

        send_byte(8'hAC, 1'b0);
        send_byte(8'hAD, 1'b0);
        check("three_full", {31'b0, rx_full}, 32'd0);
        send_byte(8'hAE, 1'b0);
        check("four_full", {31'b0, rx_full}, 32'd1);
        check("four_head", {24'b0, r_data},  32'hAB);

        read_pulse(1);
        check("pop1_data",  {24'b0, r_data},   32'hAC);
        check("pop1_full",  {31'b0, rx_full},  32'd0);
        check("pop1_empty", {31'b0, rx_empty}, 32'd0);

        send_byte(8'h0E, 1'b0);
        check("0e_full", {31'b0, rx_full}, 32'd1);
        check("0e_head", {24'b0, r_data},  32'hAC);

        read_pulse(1);
        check("pop2_data", {24'b0, r_data}, 32'hAD);
        read_pulse(1);
        check("pop3_data",  {24'b0, r_data},   32'hAE);
        check("pop3_full",  {31'b0, rx_full},  32'd0);
        check("pop3_empty", {31'b0, rx_empty}, 32'd0);

        send_byte(8'h5A, 1'b0);
        send_byte(8'h33, 1'b0);
        check("refill_full", {31'b0, rx_full}, 32'd1);
        send_byte(8'hFF, 1'b0);
        check("drop_full", {31'b0, rx_full}, 32'd1);
        check("drop_head", {24'b0, r_data},  32'hAE);

        // Wide strobe must still pop exactly once.
        read_pulse(10);
        check("wide_pop_data", {24'b0, r_data}, 32'h0E);
        read_pulse(1);
        check("drain_5a", {24'b0, r_data}, 32'h5A);
        read_pulse(1);
        check("drain_33", {24'b0, r_data}, 32'h33);
        check("drain_not_empty", {31'b0, rx_empty}, 32'd0);
        read_pulse(1);
        check("drained_empty", {31'b0, rx_empty}, 32'd1);
        check("drained_full",  {31'b0, rx_full},  32'd0);
        read_pulse(1);
        check("pop_empty_ignored", {31'b0, rx_empty}, 32'd1);
        check("pop_empty_full",    {31'b0, rx_full},  32'd0);

        send_byte(8'h96, 1'b0);
        check("wrap_data",  {24'b0, r_data},   32'h96);
        check("wrap_empty", {31'b0, rx_empty}, 32'd0);

        // Abort a frame with reset partway through its data bits.
        @(negedge clk);
        rx = 1'b0;
        #(BIT_T * 3);
        reset_pin = 1'b0;
        rx = 1'b1;
        #2;
        check("abort_busy",  {31'b0, rx_busy},  32'd0);
        check("abort_empty", {31'b0, rx_empty}, 32'd1);
        #4 reset_pin = 1'b1;
        #(BIT_T * 10);
        @(negedge clk);
        check("abort_nothing_written", {31'b0, rx_empty}, 32'd1);
        check("abort_idle",            {31'b0, rx_busy},  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
